// File: rtl/axi_resp_pkg.sv
// Shared AXI response definitions for the write-response tracker:
// BRESP code enumeration and a saturating increment for 16-bit counters.
package axi_resp_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_write_resp_tracker_if.sv
// AW/B handshake signals observed and driven by axi_write_resp_tracker.
// master: upstream initiator / bus side; slave: the tracker.
interface axi_write_resp_tracker_if #(
    parameter int ID_W = 4
);
    logic            i_awvalid;
    logic            i_awready;
    logic [ID_W-1:0] i_awid;
    logic            o_aw_block;
    logic            i_bvalid;
    logic [ID_W-1:0] i_bid;
    logic [1:0]      i_bresp;
    logic            o_bready;

    modport master (
        output i_awvalid, i_awready, i_awid, i_bvalid, i_bid, i_bresp,
        input  o_aw_block, o_bready
    );

    modport slave (
        input  i_awvalid, i_awready, i_awid, i_bvalid, i_bid, i_bresp,
        output o_aw_block, o_bready
    );
endinterface

// File: rtl/axi_resp_timeout_timer.sv
// B-channel silence timer. Only built when AXI_WRITE_RESP_TIMEOUT_EN is
// defined. Counts cycles with writes outstanding and no B handshake; raises
// a sticky flag once TIMEOUT_CYCLES is reached and holds the count there.
`ifdef AXI_WRITE_RESP_TIMEOUT_EN
module axi_resp_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic r_reset,
    input  logic i_active,
    input  logic i_b_event,
    input  logic i_clear,
    output logic o_timeout
);
    logic [31:0] silence;
    logic        hit;

    // limit reached on the current count
    always_comb begin
        hit = (silence == 32'(TIMEOUT_CYCLES));
    end

    // silence counter: restart on B or when nothing is outstanding, hold at limit
    always_ff @(posedge clk) begin
        if (!r_reset) begin
            silence <= '0;
        end else if (!i_active || i_b_event) begin
            silence <= '0;
        end else if (!hit) begin
            silence <= silence + 32'd1;
        end
    end

    // sticky timeout flag; a same-cycle hit beats the clear
    always_ff @(posedge clk) begin
        if (!r_reset) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= hit | (o_timeout & ~i_clear);
        end
    end
endmodule
`endif

// File: rtl/axi_write_resp_tracker.sv
// AXI write-response tracker: counts AW handshakes per ID, retires them on
// B handshakes, throttles AW at MAX_OUTSTANDING, classifies BRESP and keeps
// sticky protocol-error flags. Optional B-silence timeout is enabled by
// defining AXI_WRITE_RESP_TIMEOUT_EN.
module axi_write_resp_tracker
    import axi_resp_pkg::*;
#(
    parameter  int ID_W            = 4,
    parameter  int MAX_OUTSTANDING = 8,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     r_reset,
    axi_write_resp_tracker_if.slave  bus,
    input  logic                     i_clear_err,
    output logic [CNT_W-1:0]         o_outstanding,
    output logic                     o_idle,
    output logic [15:0]              o_slverr_cnt,
    output logic [15:0]              o_decerr_cnt,
    output logic                     o_err_unexpected,
    output logic                     o_err_overflow,
    output logic                     o_timeout
);
    localparam int N_ID = 2 ** ID_W;

    logic [CNT_W-1:0] id_cnt [N_ID];
    logic             bready_q;
    logic             aw_ev;
    logic             b_ev;
    logic             aw_block;
    logic             same_id;
    logic             b_ret;
    logic             b_unexp;
    logic             aw_acc;
    resp_e            bresp;
    logic [15:0]      slverr_nxt;
    logic [15:0]      decerr_nxt;

    // handshake decode; an AW on the B's ID in the same cycle makes that B
    // legal even with a zero count, and a retiring B frees room for an AW
    // that would otherwise be dropped at the limit
    always_comb begin
        aw_ev    = bus.i_awvalid & bus.i_awready;
        b_ev     = bus.i_bvalid & bready_q;
        aw_block = (o_outstanding == CNT_W'(MAX_OUTSTANDING));
        same_id  = aw_ev & (bus.i_awid == bus.i_bid);
        b_ret    = b_ev & ((id_cnt[bus.i_bid] != '0) | same_id);
        b_unexp  = b_ev & ~b_ret;
        aw_acc   = aw_ev & (~aw_block | b_ret);
        bresp    = resp_e'(bus.i_bresp);
    end

    // drive interface outputs and idle status
    always_comb begin
        bus.o_bready   = bready_q;
        bus.o_aw_block = aw_block;
        o_idle         = (o_outstanding == '0);
    end

    // B ready comes up the first cycle out of reset and stays high
    always_ff @(posedge clk) begin
        if (!r_reset) begin
            bready_q <= 1'b0;
        end else begin
            bready_q <= 1'b1;
        end
    end

    // per-ID outstanding counters
    always_ff @(posedge clk) begin
        if (!r_reset) begin
            for (int unsigned i = 0; i < N_ID; i++) begin
                id_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_ID; i++) begin
                if (aw_acc && bus.i_awid == ID_W'(i) &&
                    !(b_ret && bus.i_bid == ID_W'(i))) begin
                    id_cnt[i] <= id_cnt[i] + CNT_W'(1);
                end else if (b_ret && bus.i_bid == ID_W'(i) &&
                             !(aw_acc && bus.i_awid == ID_W'(i))) begin
                    id_cnt[i] <= id_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // total outstanding, kept equal to the sum of the per-ID counters
    always_ff @(posedge clk) begin
        if (!r_reset) begin
            o_outstanding <= '0;
        end else if (aw_acc && !b_ret) begin
            o_outstanding <= o_outstanding + CNT_W'(1);
        end else if (b_ret && !aw_acc) begin
            o_outstanding <= o_outstanding - CNT_W'(1);
        end
    end

    // error counter next values: clear first, then count this cycle's B
    always_comb begin
        slverr_nxt = i_clear_err ? '0 : o_slverr_cnt;
        decerr_nxt = i_clear_err ? '0 : o_decerr_cnt;
        if (b_ev && bresp == SLVERR) begin
            slverr_nxt = sat_inc16(slverr_nxt);
        end
        if (b_ev && bresp == DECERR) begin
            decerr_nxt = sat_inc16(decerr_nxt);
        end
    end

    // sticky flags and error counts; new errors win over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!r_reset) begin
            o_err_unexpected <= 1'b0;
            o_err_overflow   <= 1'b0;
            o_slverr_cnt     <= '0;
            o_decerr_cnt     <= '0;
        end else begin
            o_err_unexpected <= b_unexp | (o_err_unexpected & ~i_clear_err);
            o_err_overflow   <= (aw_ev & aw_block) | (o_err_overflow & ~i_clear_err);
            o_slverr_cnt     <= slverr_nxt;
            o_decerr_cnt     <= decerr_nxt;
        end
    end

`ifdef AXI_WRITE_RESP_TIMEOUT_EN
    logic busy;

    // timer runs only while writes are outstanding
    always_comb begin
        busy = (o_outstanding != '0);
    end

    axi_resp_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .clk       (clk),
        .r_reset   (r_reset),
        .i_active  (busy),
        .i_b_event (b_ev),
        .i_clear   (i_clear_err),
        .o_timeout (o_timeout)
    );
`else
    logic unused_timeout_cfg;

    // timeout feature absent: flag tied low
    always_comb begin
        o_timeout          = 1'b0;
        unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    end
`endif

endmodule
